vx_tc_smem_responder: RTL and testbench

//  Responder (slave) end of VX_tc_bus_if: serves the tensor core's A/B operand read requests from a local SRAM.

---
 rtl/vx_tc_smem_responder_pkg.sv | 23 ++
 rtl/tc_smem_bank.sv | 36 +++
 rtl/vx_fifo_queue.sv | 57 +++++
 rtl/vx_tc_smem_responder.sv | 132 +++++++++++++
 tb/tb_vx_tc_smem_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_tc_smem_responder_pkg.sv
// rtl/vx_tc_smem_responder_pkg.sv - shared types and constants for the tensor-core operand SRAM responder
// Purpose: default bus widths, the line size in bytes and the request/response payload structs
//          shared by the responder, its SRAM bank and its neighbours on the operand bus.
// Ports:   none (package).
package vx_tc_smem_responder_pkg;

  localparam int TC_SMEM_ADDR_WIDTH = 32;
  localparam int TC_SMEM_DATA_WIDTH = 256;
  localparam int TC_SMEM_TAG_WIDTH  = 8;
  localparam int TC_SMEM_NUM_LINES  = 512;
  localparam int TC_SMEM_LINE_BYTES = TC_SMEM_DATA_WIDTH / 8;

  typedef struct packed {
    logic [TC_SMEM_ADDR_WIDTH-1:0] addr;
    logic [TC_SMEM_TAG_WIDTH-1:0]  tag;
  } tc_smem_req_t;

  typedef struct packed {
    logic [TC_SMEM_DATA_WIDTH-1:0] data;
    logic [TC_SMEM_TAG_WIDTH-1:0]  tag;
  } tc_smem_rsp_t;

endpackage

// File: rtl/tc_smem_bank.sv
// rtl/tc_smem_bank.sv - 1R1W line SRAM with a READ_LATENCY-deep registered read path
// Purpose: local operand storage. Read-first on a same-cycle read/write of one line.
// Ports:   clk; rd_en/rd_idx start a read, rd_data is valid READ_LATENCY cycles later;
//          wr_en/wr_idx/wr_data write one line. Contents are never reset.
module tc_smem_bank #(
  parameter int DATA_WIDTH   = 256,
  parameter int NUM_LINES    = 512,
  parameter int READ_LATENCY = 2,
  parameter int IDX_BITS     = $clog2(NUM_LINES)
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [IDX_BITS-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_BITS-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_LINES];
  logic [DATA_WIDTH-1:0] rd_pipe [READ_LATENCY];

  // Non-blocking write plus a read of the same array in one block gives the old line on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_pipe[0] <= mem[rd_idx];
  end

  // Later stages shift every cycle so they stay in step with the responder's valid/tag pipeline.
  always_ff @(posedge clk) begin
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign rd_data = rd_pipe[READ_LATENCY-1];

endmodule

// File: rtl/vx_fifo_queue.sv
// rtl/vx_fifo_queue.sv - synchronous FIFO with first-word-fall-through output
// Purpose: response queue. data_out shows the head entry whenever empty is low.
// Ports:   clk, reset (sync, active-high); push/data_in write; pop removes the head; empty.
module vx_fifo_queue #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full));
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vx_tc_smem_responder.sv
// rtl/vx_tc_smem_responder.sv - responder end of the tensor-core operand bus, served from a local SRAM
// Purpose: accepts {addr, tag}, reads one line READ_LATENCY cycles later and returns {data, tag} in
//          request order through a response FIFO. A credit counter (in-flight + queued) gates req_ready,
//          so a response is never dropped.
// Ports:   clk, reset (sync, active-high); req_valid/req_ready/req_addr/req_tag request channel;
//          rsp_valid/rsp_ready/rsp_tag/rsp_data response channel; wr_en/wr_addr/wr_data fill port.
// Option:  TC_SMEM_PERF_EN adds perf_req_count (accepted requests) and perf_stall_count
//          (cycles with req_valid && !req_ready), both 32-bit saturating.
module vx_tc_smem_responder
  import vx_tc_smem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH      = TC_SMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = TC_SMEM_DATA_WIDTH,
  parameter int TAG_WIDTH       = TC_SMEM_TAG_WIDTH,
  parameter int NUM_LINES       = TC_SMEM_NUM_LINES,
  parameter int READ_LATENCY    = 2,
  parameter int RSP_QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic [DATA_WIDTH-1:0] rsp_data,
`ifdef TC_SMEM_PERF_EN
  output logic [31:0]           perf_req_count,
  output logic [31:0]           perf_stall_count,
`endif
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int CNT_W    = $clog2(RSP_QUEUE_DEPTH + 1);

  logic                          req_fire;
  logic                          rsp_fire;
  logic [CNT_W-1:0]              credit_cnt;
  logic [IDX_BITS-1:0]           rd_idx;
  logic [IDX_BITS-1:0]           wr_idx;
  logic [DATA_WIDTH-1:0]         bank_rd_data;
  logic [READ_LATENCY-1:0]       pipe_valid;
  logic [TAG_WIDTH-1:0]          pipe_tag [READ_LATENCY];
  logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_dout;
  logic                          fifo_empty;
  logic                          unused_addr_bits;

  // Ready comes straight from the counter so it never depends on req_valid or rsp_ready.
  assign req_ready = (credit_cnt < CNT_W'(RSP_QUEUE_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Offset bits and bits above the line index are dropped: addresses wrap modulo NUM_LINES.
  assign rd_idx           = req_addr[OFF_BITS +: IDX_BITS];
  assign wr_idx           = wr_addr[OFF_BITS +: IDX_BITS];
  assign unused_addr_bits = ^{req_addr, wr_addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= '0;
    end else begin
      assert (credit_cnt <= CNT_W'(RSP_QUEUE_DEPTH));
      assert (!(rsp_fire && !req_fire && credit_cnt == '0));
      if (req_fire && !rsp_fire)      credit_cnt <= credit_cnt + CNT_W'(1);
      else if (!req_fire && rsp_fire) credit_cnt <= credit_cnt - CNT_W'(1);
    end
  end

  tc_smem_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_LINES   (NUM_LINES),
    .READ_LATENCY(READ_LATENCY),
    .IDX_BITS    (IDX_BITS)
  ) bank (
    .clk    (clk),
    .rd_en  (req_fire),
    .rd_idx (rd_idx),
    .rd_data(bank_rd_data),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_data(wr_data)
  );

  // Valid/tag shadow of the SRAM read pipeline; the last stage lines up with bank_rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= req_fire;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
    pipe_tag[0] <= req_tag;
    for (int i = 1; i < READ_LATENCY; i++) pipe_tag[i] <= pipe_tag[i-1];
  end

  // Push is unconditional: the credit counter already reserved a FIFO slot for every read in flight.
  vx_fifo_queue #(
    .DATAW(DATA_WIDTH + TAG_WIDTH),
    .DEPTH(RSP_QUEUE_DEPTH)
  ) rsp_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (pipe_valid[READ_LATENCY-1]),
    .pop     (rsp_fire),
    .data_in ({bank_rd_data, pipe_tag[READ_LATENCY-1]}),
    .data_out(fifo_dout),
    .empty   (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_dout[TAG_WIDTH +: DATA_WIDTH];
  assign rsp_tag   = fifo_dout[TAG_WIDTH-1:0];

`ifdef TC_SMEM_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_req_count   <= '0;
      perf_stall_count <= '0;
    end else begin
      if (req_fire && perf_req_count != '1) perf_req_count <= perf_req_count + 32'd1;
      if (req_valid && !req_ready && perf_stall_count != '1) perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_tc_smem_responder.sv
// tb/tb_vx_tc_smem_responder.sv - self-checking bench for vx_tc_smem_responder
module tb_vx_tc_smem_responder;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TW = 8;
  localparam int NL = 512;
  localparam int QD = 4;
  localparam int LAT = 3;
  localparam int LB = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [TW-1:0] rsp_tag;
  logic [DW-1:0] rsp_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef TC_SMEM_PERF_EN
  logic [31:0]   perf_req_count;
  logic [31:0]   perf_stall_count;
`endif

  vx_tc_smem_responder dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_tag  (req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_tag  (rsp_tag),
    .rsp_data (rsp_data),
`ifdef TC_SMEM_PERF_EN
    .perf_req_count  (perf_req_count),
    .perf_stall_count(perf_stall_count),
`endif
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    int            cyc;
  } txn_t;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            outstanding = 0;
  int            total_acc = 0;
  int            stall_seen = 0;
  logic [DW-1:0] model_mem [NL];
  txn_t          exp_q [$];
  txn_t          obs_q [$];

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / LB) % NL);
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Advance one clock. Handshakes are recorded against the reference memory before the
  // fill write is applied, so a same-cycle read sees the old line.
  task automatic tick();
    txn_t t;
    if (!reset) begin
      if (req_valid && req_ready) begin
        t.tag = req_tag; t.data = model_mem[line_of(req_addr)]; t.cyc = cyc;
        exp_q.push_back(t); outstanding++; total_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        t.tag = rsp_tag; t.data = rsp_data; t.cyc = cyc;
        obs_q.push_back(t); outstanding--;
      end
      if (req_valid && !req_ready) stall_seen++;
    end
    if (wr_en) model_mem[line_of(wr_addr)] = wr_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill(input int line, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(line * LB); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && outstanding > 0; i++) tick();
    n_checks++;
    if (outstanding != 0) begin
      n_fail++;
      $display("FAIL %s_drain: outstanding=%0d after budget, want 0", name, outstanding);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
    req_addr = '0; req_tag = '0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
`ifdef TC_SMEM_PERF_EN
    n_checks++;
    if (perf_req_count !== 32'd0 || perf_stall_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_perf: got req=%0d stall=%0d want 0 0", perf_req_count, perf_stall_count);
    end
`endif
  endtask

  task automatic test_basic();
    int t0;
    fill(3, {32{8'hA5}});
    rsp_ready = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", req_ready); end
    req_valid = 1'b1; req_addr = 32'h60; req_tag = 8'd7;
    t0 = cyc;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10 && rsp_valid !== 1'b1; i++) tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || cyc != t0 + LAT) begin
      n_fail++; $display("FAIL basic_latency: rsp_valid=%b at cycle offset %0d, want 1 at %0d", rsp_valid, cyc - t0, LAT);
    end
    n_checks++;
    if (rsp_tag !== 8'd7) begin n_fail++; $display("FAIL basic_tag: got %0d want 7", rsp_tag); end
    n_checks++;
    if (rsp_data !== {32{8'hA5}}) begin n_fail++; $display("FAIL basic_data: got %h want %h", rsp_data, {32{8'hA5}}); end
    drain("basic");
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h4060; req_tag = 8'h55;
    tick();
    drain("wrap");
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL wrap_count: got %0d rsps want 1", obs_q.size());
    end else if (obs_q[0].tag !== 8'h55 || obs_q[0].data !== {32{8'hA5}}) begin
      n_fail++; $display("FAIL wrap_data: got tag=%h data=%h want tag=55 data=%h", obs_q[0].tag, obs_q[0].data, {32{8'hA5}});
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) fill(16 + i, rand_line());
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1;
      req_addr  = ($urandom << 14) | AW'((16 + i) * LB);
      req_tag   = TW'(i);
      n_checks++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
      tick();
    end
    drain("b2b");
    n_checks++;
    if (obs_q.size() != 10) begin n_fail++; $display("FAIL b2b_count: got %0d want 10", obs_q.size()); end
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].tag !== TW'(i) || obs_q[i].data !== exp_q[i].data
          || obs_q[i].cyc != exp_q[0].cyc + LAT + i) begin
        n_fail++;
        $display("FAIL b2b_rsp[%0d]: got tag=%0d cyc=%0d data=%h want tag=%0d cyc=%0d data=%h",
                 i, obs_q[i].tag, obs_q[i].cyc, obs_q[i].data, i, exp_q[0].cyc + LAT + i, exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_credits();
    logic [TW-1:0] hold_tag;
    logic [DW-1:0] hold_data;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 32'h60; req_tag = TW'(100 + i);
      tick();
    end
    req_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != QD) begin n_fail++; $display("FAIL credit_accepted: got %0d want %0d", exp_q.size(), QD); end
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL credit_ready_low: got %b want 0", req_ready); end
    hold_tag = rsp_tag; hold_data = rsp_data;
    n_checks++;
    if (rsp_valid !== 1'b1 || hold_tag !== TW'(100)) begin
      n_fail++; $display("FAIL credit_head: got valid=%b tag=%0d want 1 100", rsp_valid, hold_tag);
    end
    repeat (3) tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== hold_tag || rsp_data !== hold_data) begin
      n_fail++; $display("FAIL credit_hold: got valid=%b tag=%0d want 1 %0d with data unchanged", rsp_valid, rsp_tag, hold_tag);
    end
    drain("credit");
    n_checks++;
    if (obs_q.size() != QD) begin n_fail++; $display("FAIL credit_rsp_count: got %0d want %0d", obs_q.size(), QD); end
    for (int i = 0; i < QD && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].tag !== TW'(100 + i) || obs_q[i].data !== {32{8'hA5}}) begin
        n_fail++; $display("FAIL credit_rsp[%0d]: got tag=%0d data=%h want tag=%0d data=%h", i, obs_q[i].tag, obs_q[i].data, 100 + i, {32{8'hA5}});
      end
    end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL credit_ready_back: got %b want 1", req_ready); end
`ifdef TC_SMEM_PERF_EN
    n_checks++;
    if (perf_req_count !== 32'(total_acc)) begin n_fail++; $display("FAIL perf_req_count: got %0d want %0d", perf_req_count, total_acc); end
    n_checks++;
    if (perf_stall_count !== 32'(stall_seen) || stall_seen == 0) begin
      n_fail++; $display("FAIL perf_stall_count: got %0d want %0d (nonzero)", perf_stall_count, stall_seen);
    end
`endif
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_collision();
    fill(5, {32{8'h22}});
    rsp_ready = 1'b1;
    wr_en = 1'b1; wr_addr = AW'(5 * LB); wr_data = {32{8'h11}};
    req_valid = 1'b1; req_addr = AW'(5 * LB); req_tag = 8'd1;
    tick();
    wr_en = 1'b0;
    req_tag = 8'd2;
    tick();
    drain("collision");
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL collision_count: got %0d want 2", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0].tag !== 8'd1 || obs_q[0].data !== {32{8'h22}}) begin
        n_fail++; $display("FAIL collision_old: got tag=%0d data=%h want tag=1 data=%h", obs_q[0].tag, obs_q[0].data, {32{8'h22}});
      end
      n_checks++;
      if (obs_q[1].tag !== 8'd2 || obs_q[1].data !== {32{8'h11}}) begin
        n_fail++; $display("FAIL collision_new: got tag=%0d data=%h want tag=2 data=%h", obs_q[1].tag, obs_q[1].data, {32{8'h11}});
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic          hold;
    logic [TW-1:0] hold_tag;
    logic [DW-1:0] hold_data;
    for (int i = 0; i < 16; i++) fill(i, rand_line());
    hold = 1'b0; hold_tag = '0; hold_data = '0;
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = ($urandom << 14) | AW'($urandom_range(0, 15) * LB);
      req_tag   = TW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      wr_en     = ($urandom_range(0, 7) == 0);
      wr_addr   = AW'($urandom_range(0, 15) * LB);
      wr_data   = rand_line();
      n_checks++;
      if (req_ready !== (outstanding < QD)) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b (outstanding=%0d)", c, req_ready, outstanding < QD, outstanding);
      end
      if (hold) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== hold_tag || rsp_data !== hold_data) begin
          n_fail++; $display("FAIL rand_hold[%0d]: got valid=%b tag=%h want 1 %h with data unchanged", c, rsp_valid, rsp_tag, hold_tag);
        end
      end
      hold = rsp_valid && !rsp_ready; hold_tag = rsp_tag; hold_data = rsp_data;
      tick();
    end
    wr_en = 1'b0;
    drain("rand");
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d rsps want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].tag !== exp_q[i].tag || obs_q[i].data !== exp_q[i].data || obs_q[i].cyc < exp_q[i].cyc + LAT) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got tag=%h cyc=%0d data=%h want tag=%h min_cyc=%0d data=%h",
                 i, obs_q[i].tag, obs_q[i].cyc, obs_q[i].data, exp_q[i].tag, exp_q[i].cyc + LAT, exp_q[i].data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 32'h60; req_tag = TW'(200 + i);
      tick();
    end
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    outstanding = 0; total_acc = 0; stall_seen = 0;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_rsp_valid[%0d]: got %b want 0", i, rsp_valid); end
      tick();
    end
`ifdef TC_SMEM_PERF_EN
    n_checks++;
    if (perf_req_count !== 32'd0) begin n_fail++; $display("FAIL midreset_perf: got %0d want 0", perf_req_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_credits();
    test_collision();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
